// File: rtl/mul_32bits_seq.sv
// Unsigned 32x32->64 iterative shift-and-add multiplier.
// One add per cycle over 32 cycles through a single adder_32bits instance.
//
// Handshake: start is sampled only when the unit is idle (IDLE or DONE);
// a sampled start captures a/b at that rising edge. busy is high for the
// 32 iteration cycles, done is a one-cycle pulse when p has just been
// updated, and p holds its value until the next completion. start while
// busy is ignored; there is no abort other than rst.

// 32-bit carry-select adder: ripple low half, both carry cases precomputed
// for the high half, selected by the low-half carry.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [16:0] lo_sum;
  logic [16:0] hi_sum0;
  logic [16:0] hi_sum1;

  assign lo_sum  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, ci};
  assign hi_sum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hi_sum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

  assign s  = {(lo_sum[16] ? hi_sum1[15:0] : hi_sum0[15:0]), lo_sum[15:0]};
  assign co = lo_sum[16] ? hi_sum1[16] : hi_sum0[16];
endmodule

module mul_32bits_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [5:0]  cnt;

  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_co;
  logic [63:0] shifted;
  logic        accept;

  // Add the multiplicand into the upper half only when the current
  // multiplier bit (acc_lo[0]) is set.
  assign add_b = acc_lo[0] ? mcand : 32'h0;

  adder_32bits u_adder (
    .a  (acc_hi),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  // 65-bit {co, s, acc_lo} shifted right by one; the dropped bit is the
  // multiplier bit just consumed.
  assign shifted = {add_co, add_s, acc_lo[31:1]};

  // DONE accepts a new start exactly like IDLE, giving back-to-back runs.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Sequencing, datapath iteration and product capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mcand  <= 32'h0;
      acc_hi <= 32'h0;
      acc_lo <= 32'h0;
      cnt    <= 6'd0;
      p      <= 64'h0;
    end else begin
      case (state)
        S_RUN: begin
          acc_hi <= shifted[63:32];
          acc_lo <= shifted[31:0];
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= S_DONE;
            p     <= shifted;
          end
        end
        S_IDLE, S_DONE: begin
          if (accept) begin
            mcand  <= a;
            acc_hi <= 32'h0;
            acc_lo <= b;
            cnt    <= 6'd0;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_mul_32bits_seq.sv
// Testbench for mul_32bits_seq: cycle-level reference model (countdown +
// native 64-bit multiply) checked every cycle, plus directed scenarios with
// hand-computed products.
module tb_mul_32bits_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Reference model state.
  int          m_rem  = 0;
  bit          m_done = 0;
  logic [63:0] m_p    = 64'h0;
  logic [63:0] m_pend = 64'h0;

  logic [63:0] exp_q[$];

  mul_32bits_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Clock / reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a start while idle schedules a product 32 edges later; done is
  // high for the single cycle after that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 0;
      m_p    = 64'h0;
      exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1;
        m_p    = exp_q.pop_front();
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_rem  = 32;
        m_pend = {32'h0, a} * {32'h0, b};
        exp_q.push_back(m_pend);
      end
    end
  end

  // Per-cycle scoreboard compare, away from the rising edge.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_busy", {63'h0, busy}, {63'h0, (m_rem > 0)});
      check("cyc_done", {63'h0, done}, {63'h0, m_done});
      check("cyc_p", p, m_p);
    end
  end

  // Wait (bounded) for done; cycles counts negedges observed.
  task automatic wait_done(input int limit, output int cycles, output bit seen);
    seen   = 0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      #1;
      cycles++;
      if (done) seen = 1;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp_p);
    int  cyc;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc, seen);
    check({name, "_seen"}, {63'h0, seen}, 64'h1);
    check({name, "_lat"}, 64'(cyc), 64'd32);
    check({name, "_p"}, p, exp_p);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst   = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #2;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_p", p, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products.
    run_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("zero", 32'h0, 32'h1234_5678, 64'h0);
    run_op("ident", 32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc, seen);
    check("busy_start_lat", 64'(cyc), 64'd22);
    check("busy_start_p", p, 64'd42);
    wait_done(40, cyc, seen);
    check("busy_start_no_2nd", {63'h0, seen}, 64'h0);

    // Reset mid-run discards the operation.
    @(negedge clk);
    start = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    check("midrst_p", p, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(40, cyc, seen);
    check("midrst_no_done", {63'h0, seen}, 64'h0);
    run_op("after_rst", 32'd10, 32'd10, 64'd100);

    // Back-to-back: start held, new operands presented in DONE.
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    wait_done(40, cyc, seen);
    check("b2b_first_lat", 64'(cyc), 64'd33);
    check("b2b_first_p", p, 64'hF);
    a = 32'h0001_0000; b = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("b2b_no_idle", {63'h0, busy}, 64'h1);
    check("b2b_p_hold", p, 64'hF);
    wait_done(40, cyc, seen);
    check("b2b_second_lat", 64'(cyc), 64'd32);
    check("b2b_second_p", p, 64'h0000_0001_0000_0000);

    // Random operands, back-to-back, checked by the model.
    @(negedge clk);
    start = 1'b1;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < 1000; i++) begin
      wait_done(40, cyc, seen);
      check("rand_seen", {63'h0, seen}, 64'h1);
      if (!seen) break;
      if (i < 999) begin
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
